// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared ALU definitions used by the decimal digit reader (dgt_seq) and the
//   digit-set op (dst): accumulator width, BCD digit count, the BCD shift
//   register type and the digit reader FSM state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ACC_W      = 11;               // accumulator width, two's complement
  localparam int BCD_DIGITS = 3;                // BCD digits held in the shift register
  localparam int BCD_MAX    = 999;              // largest magnitude representable in BCD_DIGITS
  localparam int BCD_W      = 4 * BCD_DIGITS;   // BCD shift register width
  localparam int MAG_W      = ACC_W - 1;        // magnitude bits shifted in by double-dabble
  localparam int CNT_W      = $clog2(MAG_W);    // iteration counter width
  localparam int CNT_LAST   = MAG_W - 1;        // counter value on the final iteration edge

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } dgt_state_t;

  // Full-width magnitude. The most negative value maps to 2**(ACC_W-1),
  // which only fits because the result keeps all ACC_W bits.
  function automatic logic [ACC_W-1:0] acc_abs(input logic [ACC_W-1:0] a);
    return a[ACC_W-1] ? (~a + 1'b1) : a;
  endfunction

endpackage

// File: rtl/dgt_seq_if.sv
// ---------------------------------------------------------------------------
// dgt_seq_if
//   Request/response handshake bundle for the decimal digit reader.
//   Request side : in_valid, in_ready, acc, idx
//   Response side: out_valid, out_ready, digit, neg, err
//   Modports: slave (the digit reader), master (the sequencer driving it).
// ---------------------------------------------------------------------------
interface dgt_seq_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc;
  logic [1:0]       idx;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       digit;
  logic             neg;
  logic             err;

  modport slave (
    input  in_valid, acc, idx, out_ready,
    output in_ready, out_valid, digit, neg, err
  );

  modport master (
    output in_valid, acc, idx, out_ready,
    input  in_ready, out_valid, digit, neg, err
  );

endinterface

// File: rtl/dgt_seq_dd_step.sv
// ---------------------------------------------------------------------------
// dd_step
//   One combinational double-dabble iteration: every BCD nibble >= 5 gets +3,
//   then the register shifts left by one with the next magnitude bit entering
//   at the bottom.
//   Ports:
//     i_bcd  in   bcd_t  current BCD shift register
//     i_bit  in   1      next magnitude bit (MSB first)
//     o_bcd  out  bcd_t  updated BCD shift register
// ---------------------------------------------------------------------------
module dd_step
  import alu_pkg::*;
(
  input  bcd_t i_bcd,
  input  logic i_bit,
  output bcd_t o_bcd
);

  bcd_t w_adj;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_nib
      assign w_adj[4*gi +: 4] = (i_bcd[4*gi +: 4] >= 4'd5) ? (i_bcd[4*gi +: 4] + 4'd3)
                                                           : i_bcd[4*gi +: 4];
    end
  endgenerate

  // The top bit shifted out is only non-zero for out-of-range inputs, whose
  // digit is forced to zero anyway, so it is dropped.
  assign o_bcd = {w_adj[BCD_W-2:0], i_bit};

endmodule

// File: rtl/dgt_seq.sv
// ---------------------------------------------------------------------------
// dgt_seq
//   Multi-cycle decimal digit reader. Accepts a signed accumulator and a digit
//   index, converts |acc| to BCD with iterative double-dabble (one bit per
//   cycle) and returns the selected decimal digit plus sign and range flags.
//   Latency: accept on edge E0, out_valid after edge E(ACC_W-1).
//   Ports:
//     clk    in   1            clock, rising edge
//     rst_n  in   1            asynchronous active-low reset
//     bus    slave modport     in_valid/in_ready/acc/idx request,
//                              out_valid/out_ready/digit/neg/err response
//   Build option:
//     DGT_SIGN_EN  when defined, idx=3 returns {3'b000, neg}; otherwise 0.
// ---------------------------------------------------------------------------
module dgt_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  dgt_seq_if.slave   bus
);

  dgt_state_t       r_state;
  dgt_state_t       w_state_next;
  logic             w_accept;
  logic             w_last_iter;

  logic [MAG_W-1:0] r_mag;
  bcd_t             r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_neg;
  logic             r_err;
  logic [3:0]       r_digit;

  logic [ACC_W-1:0] w_mag_full;
  bcd_t             w_bcd_step;
  logic [3:0]       w_digit_sel;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_last_iter = (r_cnt == CNT_W'(CNT_LAST));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV: begin
        if (w_last_iter) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  assign w_mag_full = acc_abs(bus.acc);

  dd_step u_dd_step (
    .i_bcd (r_bcd),
    .i_bit (r_mag[MAG_W-1]),
    .o_bcd (w_bcd_step)
  );

  // Selection is taken from the final iteration's result so that the digit
  // register is loaded on the same edge that enters DONE.
  always_comb begin
    w_digit_sel = 4'd0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_idx == 2'(i)) begin
        w_digit_sel = w_bcd_step[4*i +: 4];
      end
    end
`ifdef DGT_SIGN_EN
    if (r_idx == 2'd3) begin
      w_digit_sel = {3'b000, r_neg};
    end
`endif
    if (r_err) begin
      w_digit_sel = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_digit <= 4'd0;
    end else if (w_accept) begin
      r_mag <= w_mag_full[MAG_W-1:0];
      r_bcd <= '0;
      r_cnt <= '0;
      r_idx <= bus.idx;
      r_neg <= bus.acc[ACC_W-1];
      r_err <= (w_mag_full > ACC_W'(BCD_MAX));
    end else if (r_state == CONV) begin
      r_bcd <= w_bcd_step;
      r_mag <= {r_mag[MAG_W-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      if (w_last_iter) begin
        r_digit <= w_digit_sel;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.digit     = r_digit;
  assign bus.neg       = r_neg;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_dgt_seq.sv
// ---------------------------------------------------------------------------
// tb_dgt_seq
//   Self-checking bench for dgt_seq: a vector table of spec cases plus random
//   requests checked against an arithmetic reference, and hand-written
//   sequences for back-pressure and mid-conversion reset.
//   Build option: DGT_SIGN_EN (must match the RTL build).
// ---------------------------------------------------------------------------
module tb_dgt_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dgt_seq_if bus ();

  dgt_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int digit;
    int neg;
    int err;
  } exp_t;

  typedef struct {
    int acc;
    int idx;
    int digit;
    int neg;
    int err;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

`ifdef DGT_SIGN_EN
  localparam int SIGN_EN = 1;
`else
  localparam int SIGN_EN = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Arithmetic reference: decimal digit by division, independent of BCD shifting.
  function automatic exp_t model(input int a, input int ix);
    exp_t e;
    int   m;
    m       = (a < 0) ? -a : a;
    e.neg   = (a < 0) ? 1 : 0;
    e.err   = (m > BCD_MAX) ? 1 : 0;
    e.digit = 0;
    if (e.err == 0) begin
      if (ix < BCD_DIGITS) e.digit = (m / (10 ** ix)) % 10;
      else if (SIGN_EN != 0) e.digit = e.neg;
    end
    return e;
  endfunction

  // Wait for in_ready, present one request for one edge, push expectation.
  task automatic issue(input int a, input int ix, input exp_t e, input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({name, ".in_ready"}, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.acc      = ACC_W'(a);
    bus.idx      = 2'(ix);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(e);
  endtask

  // Count cycles from accept to out_valid, compare against scoreboard head.
  task automatic collect(input string name, input int a, input int ix, input bit release_now);
    int   k;
    exp_t e;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    check({name, ".latency"}, k, ACC_W - 1);
    if (sb_q.size() == 0) begin
      check({name, ".scoreboard"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({name, ".digit"}, int'(bus.digit), e.digit);
      check({name, ".neg"},   int'(bus.neg),   e.neg);
      check({name, ".err"},   int'(bus.err),   e.err);
      $display("%s: acc=%0d idx=%0d -> digit=%0d neg=%0d err=%0d latency=%0d (exp %0d/%0d/%0d)",
               name, a, ix, bus.digit, bus.neg, bus.err, k, e.digit, e.neg, e.err);
    end
    if (release_now) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({name, ".idle_in_ready"},  int'(bus.in_ready),  1);
      check({name, ".idle_out_valid"}, int'(bus.out_valid), 0);
    end
  endtask

  initial begin
    exp_t e;
    int   a;
    int   ix;
    logic [3:0] h_digit;
    logic       h_neg;
    logic       h_err;

    bus.in_valid  = 1'b0;
    bus.acc       = '0;
    bus.idx       = '0;
    bus.out_ready = 1'b0;

    tbl.push_back('{345,   0, 5, 0, 0});
    tbl.push_back('{345,   1, 4, 0, 0});
    tbl.push_back('{345,   2, 3, 0, 0});
    tbl.push_back('{-907,  1, 0, 1, 0});
    tbl.push_back('{-907,  2, 9, 1, 0});
    tbl.push_back('{-42,   3, SIGN_EN, 1, 0});
    tbl.push_back('{42,    3, 0, 0, 0});
    tbl.push_back('{1000,  0, 0, 0, 1});
    tbl.push_back('{-1024, 2, 0, 1, 1});
    tbl.push_back('{999,   2, 9, 0, 0});
    tbl.push_back('{0,     1, 0, 0, 0});
    tbl.push_back('{-999,  0, 9, 1, 0});
    tbl.push_back('{1023,  1, 0, 0, 1});
    tbl.push_back('{-1,    0, 1, 1, 0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready",  int'(bus.in_ready),  1);
    check("reset.out_valid", int'(bus.out_valid), 0);
    check("reset.digit",     int'(bus.digit),     0);
    check("reset.neg",       int'(bus.neg),       0);
    check("reset.err",       int'(bus.err),       0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      e.digit = tbl[i].digit;
      e.neg   = tbl[i].neg;
      e.err   = tbl[i].err;
      issue(tbl[i].acc, tbl[i].idx, e, $sformatf("vec%0d", i));
      collect($sformatf("vec%0d", i), tbl[i].acc, tbl[i].idx, 1'b1);
    end

    // Random vectors against the arithmetic reference
    for (int i = 0; i < 8; i++) begin
      a  = int'($urandom_range(0, 2047)) - 1024;
      ix = int'($urandom_range(0, 3));
      issue(a, ix, model(a, ix), $sformatf("rnd%0d", i));
      collect($sformatf("rnd%0d", i), a, ix, 1'b1);
    end

    // Back-pressure: hold DONE for 5 cycles with a competing request pending
    issue(-587, 1, model(-587, 1), "hold");
    collect("hold", -587, 1, 1'b0);
    h_digit = bus.digit;
    h_neg   = bus.neg;
    h_err   = bus.err;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.acc      = ACC_W'(123);
    bus.idx      = 2'd1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold.out_valid", int'(bus.out_valid), 1);
      check("hold.in_ready",  int'(bus.in_ready),  0);
      check("hold.digit",     int'(bus.digit),     int'(h_digit));
      check("hold.neg",       int'(bus.neg),       int'(h_neg));
      check("hold.err",       int'(bus.err),       int'(h_err));
    end
    $display("hold: outputs held 5 cycles digit=%0d neg=%0d err=%0d", h_digit, h_neg, h_err);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("hold.release_in_ready",  int'(bus.in_ready),  1);
    check("hold.release_out_valid", int'(bus.out_valid), 0);
    // Pending request is taken on the following edge
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("hold.reaccept_in_ready", int'(bus.in_ready), 0);
    sb_q.push_back(model(123, 1));
    collect("reaccept", 123, 1, 1'b1);

    // Reset in the middle of conversion
    issue(678, 2, model(678, 2), "abort");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", int'(bus.out_valid), 0);
    check("abort.in_ready",  int'(bus.in_ready),  1);
    check("abort.digit",     int'(bus.digit),     0);
    repeat (2) @(posedge clk);
    #1;
    check("abort.hold_out_valid", int'(bus.out_valid), 0);
    check("abort.hold_in_ready",  int'(bus.in_ready),  1);
    $display("abort: reset during CONV, out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    issue(-256, 0, model(-256, 0), "post_reset");
    collect("post_reset", -256, 0, 1'b1);

    check("scoreboard.empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
